serial_slave_port: RTL and testbench

- Slave-side responder for the 1-bit serial shared bus. One instance sits behind each slave port (s1/s2/s3) of the bus arbiter.
- Deserialises address and write data from the bus, stores data in a local synchronous RAM, and serialises read data back toward the master.
- Drives the ready, hold (split) and valid_out handshakes that the arbiter uses for connection and split decisions.

---
 rtl/serial_slave_pkg.sv | 17 +
 rtl/serial_slave_ram.sv | 22 ++
 rtl/serial_slave_port.sv | 166 ++++++++++++++++
 tb/tb_serial_slave_port.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_slave_pkg.sv
// Shared state encoding and default sizing for the serial bus slave port.
package serial_slave_pkg;

    localparam int SS_ADDR_W       = 12;
    localparam int SS_DATA_W       = 8;
    localparam int SS_READ_LATENCY = 2;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        WRITE,
        RWAIT,
        RDATA
    } state_t;

endpackage

// File: rtl/serial_slave_ram.sv
// Single-port synchronous RAM with a registered, read-first read port.
module serial_slave_ram
    import serial_slave_pkg::*;
#(
    parameter int ADDR_W = SS_ADDR_W,
    parameter int DATA_W = SS_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/serial_slave_port.sv
// Slave responder for the 1-bit serial bus: deserialises address/write data, serialises reads.
// Optional even-parity bit per beat is enabled with SERIAL_SLAVE_PARITY_EN.
module serial_slave_port
    import serial_slave_pkg::*;
#(
    parameter int ADDR_W       = SS_ADDR_W,
    parameter int DATA_W       = SS_DATA_W,
    parameter int READ_LATENCY = SS_READ_LATENCY
) (
    input  logic clk,
    input  logic reset,
    input  logic s_address,
    input  logic s_data,
    input  logic s_valid,
    input  logic s_write_en,
    input  logic s_burst,
    input  logic bus_ready,
    output logic s_ready,
    output logic s_hold,
    output logic s_data_out,
    output logic s_valid_out,
    output logic s_err
);

`ifdef SERIAL_SLAVE_PARITY_EN
    localparam int BEAT_W = DATA_W + 1;
`else
    localparam int BEAT_W = DATA_W;
`endif
    localparam int MAX_W  = (ADDR_W > BEAT_W) ? ADDR_W : BEAT_W;
    localparam int CNT_W  = $clog2(MAX_W + 1);
    localparam int WAIT_W = $clog2(READ_LATENCY + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BEAT_W - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(READ_LATENCY);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr, addr_shift, addr_inc, ram_addr;
    logic [BEAT_W-1:0] wbuf, obuf, ram_beat, rd_src;
    logic [DATA_W-1:0] rdata;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wr_q, burst_q, ram_we;
    logic              adv, addr_last, beat_last, rd_slot, rd_fire, rd_last;

    assign adv        = s_valid && bus_ready;
    assign addr_last  = adv && (bit_cnt == ADDR_LAST);
    assign beat_last  = adv && (bit_cnt == BEAT_LAST);
    assign addr_shift = {addr[ADDR_W-2:0], s_address};
    assign addr_inc   = addr + ADDR_W'(1);

    // A read bit goes out either straight from RAM on the last wait cycle or from obuf.
    assign rd_slot = (state == RDATA) || ((state == RWAIT) && (wait_cnt == WAIT_ONE));
    assign rd_fire = rd_slot && bus_ready;
    assign rd_last = rd_fire && (bit_cnt == BEAT_LAST);
    assign rd_src  = (state == RWAIT) ? ram_beat : obuf;

`ifdef SERIAL_SLAVE_PARITY_EN
    assign ram_beat = {rdata, ^rdata};
    assign ram_we   = (state == WRITE) && !(^wbuf);
`else
    assign ram_beat = rdata;
    assign ram_we   = (state == WRITE);
    assign s_err    = 1'b0;
`endif

    // The read is launched while the final address bit is shifting in so it is ready on RWAIT entry.
    always_comb begin
        case (state)
            IDLE, ADDR: ram_addr = addr_shift;
            RDATA:      ram_addr = addr_inc;
            default:    ram_addr = addr;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (adv) state_n = ADDR;
            ADDR:  if (addr_last) state_n = wr_q ? WDATA : RWAIT;
            WDATA: if (beat_last) state_n = WRITE;
            WRITE: state_n = burst_q ? WDATA : IDLE;
            RWAIT: if (wait_cnt == WAIT_ONE)
                       state_n = rd_last ? (s_burst ? RWAIT : IDLE) : RDATA;
            RDATA: if (rd_last) state_n = s_burst ? RWAIT : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            s_ready     <= 1'b1;
            s_hold      <= 1'b0;
            s_data_out  <= 1'b0;
            s_valid_out <= 1'b0;
            addr        <= '0;
            wbuf        <= '0;
            obuf        <= '0;
            bit_cnt     <= '0;
            wait_cnt    <= '0;
            wr_q        <= 1'b0;
            burst_q     <= 1'b0;
`ifdef SERIAL_SLAVE_PARITY_EN
            s_err       <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            s_ready     <= (state_n == IDLE);
            s_hold      <= (state_n == RWAIT);
            s_valid_out <= 1'b0;
`ifdef SERIAL_SLAVE_PARITY_EN
            s_err <= (state == WDATA) && beat_last && (^{wbuf[BEAT_W-2:0], s_data});
`endif
            case (state)
                IDLE: if (adv) begin
                    addr    <= addr_shift;
                    wr_q    <= s_write_en;
                    bit_cnt <= CNT_ONE;
                end
                ADDR: if (adv) begin
                    addr     <= addr_shift;
                    bit_cnt  <= addr_last ? '0 : bit_cnt + CNT_ONE;
                    wait_cnt <= WAIT_INIT;
                end
                WDATA: if (adv) begin
                    wbuf    <= {wbuf[BEAT_W-2:0], s_data};
                    bit_cnt <= beat_last ? '0 : bit_cnt + CNT_ONE;
                    if (beat_last) burst_q <= s_burst;
                end
                WRITE: if (burst_q) addr <= addr_inc;
                RWAIT, RDATA: begin
                    if (state == RWAIT) wait_cnt <= wait_cnt - WAIT_ONE;
                    if (rd_fire) begin
                        s_data_out  <= rd_src[BEAT_W-1];
                        s_valid_out <= 1'b1;
                        obuf        <= rd_src << 1;
                        bit_cnt     <= rd_last ? '0 : bit_cnt + CNT_ONE;
                        if (rd_last && s_burst) begin
                            addr     <= addr_inc;
                            wait_cnt <= WAIT_INIT;
                        end
                    end else if (rd_slot) begin
                        obuf <= rd_src;
                    end
                end
                default: ;
            endcase
        end
    end

    serial_slave_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wbuf[BEAT_W-1 -: DATA_W]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_serial_slave_port.sv
// Scoreboard bench for serial_slave_port: read beats are queued at issue and checked on s_valid_out.
module tb_serial_slave_port;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int RL = 2;
`ifdef SERIAL_SLAVE_PARITY_EN
    localparam int BW = DW + 1;
`else
    localparam int BW = DW;
`endif

    logic clk = 1'b0;
    logic reset, s_address, s_data, s_valid, s_write_en, s_burst, bus_ready;
    logic s_ready, s_hold, s_data_out, s_valid_out, s_err;

    int total = 0;
    int bad   = 0;
    int hold_seen = 0;
    int err_seen  = 0;
    logic [BW-1:0] exp_q[$];

    always #5 clk = ~clk;

    serial_slave_port dut (
        .clk         (clk),
        .reset       (reset),
        .s_address   (s_address),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_write_en  (s_write_en),
        .s_burst     (s_burst),
        .bus_ready   (bus_ready),
        .s_ready     (s_ready),
        .s_hold      (s_hold),
        .s_data_out  (s_data_out),
        .s_valid_out (s_valid_out),
        .s_err       (s_err)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [BW-1:0] beat_of(input logic [DW-1:0] d);
`ifdef SERIAL_SLAVE_PARITY_EN
        return {d, ^d};
`else
        return d;
`endif
    endfunction

    task automatic tick();
        @(negedge clk);
        if (s_err)  err_seen++;
        if (s_hold) hold_seen++;
    endtask

    task automatic send_addr(input logic [AW-1:0] a, input logic we, input int stall_after,
                             input int stall_n, inout int clks);
        for (int i = AW - 1; i >= 0; i--) begin
            s_valid    = 1'b1;
            s_address  = a[i];
            s_write_en = (i == AW - 1) ? we : ~we;
            tick(); clks++;
            if (AW - i == stall_after) begin
                s_valid   = 1'b0;
                s_address = ~s_address;
                repeat (stall_n) begin tick(); clks++; end
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [BW-1:0] beat, input logic burst, inout int clks);
        for (int i = BW - 1; i >= 0; i--) begin
            s_valid = 1'b1;
            s_data  = beat[i];
            s_burst = (i == 0) ? burst : ~burst;
            tick(); clks++;
        end
        s_valid = 1'b0;
        s_burst = 1'b0;
    endtask

    task automatic wait_ready(inout int clks);
        int n = 0;
        while (!s_ready && n < 50) begin tick(); n++; end
        clks += n;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int clks = 0;
        send_addr(a, 1'b1, 0, 0, clks);
        send_beat(beat_of(d), 1'b0, clks);
        wait_ready(clks);
    endtask

    // Collects read beats and checks each one against the scoreboard as it completes.
    task automatic read_txn(input logic [AW-1:0] a, input int nbeats, input int stall_bit,
                            input int stall_n, output int leak, output int lat);
        int clks = 0;
        int beat = 0;
        int nb = 0;
        int guard = 0;
        logic [BW-1:0] sh = '0;
        logic [BW-1:0] e;
        leak = 0;
        lat = -1;
        hold_seen = 0;
        s_burst = (nbeats > 1);
        send_addr(a, 1'b0, 0, 0, clks);
        while (beat < nbeats && guard < 400) begin
            tick(); guard++;
            if (s_valid_out) begin
                if (lat < 0) lat = guard;
                sh = {sh[BW-2:0], s_data_out};
                nb++;
                if (nb == stall_bit) begin
                    bus_ready = 1'b0;
                    repeat (stall_n) begin tick(); if (s_valid_out) leak++; end
                    bus_ready = 1'b1;
                end
                if (nb == BW) begin
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
                    total++;
                    if (sh !== e) begin
                        bad++;
                        $display("FAIL sb_read addr=%h beat=%0d got=%h want=%h", a, beat, sh, e);
                    end
                    nb = 0;
                    beat++;
                    s_burst = (beat < nbeats - 1);
                end
            end
        end
        s_burst = 1'b0;
        if (beat < nbeats) begin
            total++; bad++;
            $display("FAIL read_timeout addr=%h beats=%0d want=%0d", a, beat, nbeats);
        end
        wait_ready(clks);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++;
        if ({s_ready, s_hold, s_data_out, s_valid_out, s_err} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=10000",
                     {s_ready, s_hold, s_data_out, s_valid_out, s_err});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        int clks = 0;
        int leak, lat;
        err_seen = 0;
        send_addr(12'h123, 1'b1, 0, 0, clks);
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL ready_busy got=%b want=0", s_ready); end
        send_beat(beat_of(8'hA5), 1'b0, clks);
        wait_ready(clks);
        total++;
        if (clks != AW + BW + 1) begin bad++; $display("FAIL write_latency got=%0d want=%0d", clks, AW + BW + 1); end
        total++;
        if (err_seen != 0) begin bad++; $display("FAIL write_err got=%0d want=0", err_seen); end
        exp_q.push_back(beat_of(8'hA5));
        read_txn(12'h123, 1, 0, 0, leak, lat);
        total++;
        if (hold_seen != RL) begin bad++; $display("FAIL read_hold got=%0d want=%0d", hold_seen, RL); end
        total++;
        if (lat != RL) begin bad++; $display("FAIL read_first_bit got=%0d want=%0d", lat, RL); end
    endtask

    task automatic test_burst_wrap();
        int clks = 0;
        int leak, lat;
        send_addr(12'hFFF, 1'b1, 0, 0, clks);
        send_beat(beat_of(8'h11), 1'b1, clks);
        s_valid = 1'b0;
        tick(); clks++;
        send_beat(beat_of(8'h22), 1'b0, clks);
        wait_ready(clks);
        total++;
        if (clks != AW + 2 * BW + 2) begin bad++; $display("FAIL burst_latency got=%0d want=%0d", clks, AW + 2 * BW + 2); end
        total++;
        if (dut.u_ram.mem[12'hFFF] !== 8'h11) begin bad++; $display("FAIL burst_ram_fff got=%h want=11", dut.u_ram.mem[12'hFFF]); end
        total++;
        if (dut.u_ram.mem[12'h000] !== 8'h22) begin bad++; $display("FAIL burst_ram_000 got=%h want=22", dut.u_ram.mem[12'h000]); end
        exp_q.push_back(beat_of(8'h11));
        exp_q.push_back(beat_of(8'h22));
        read_txn(12'hFFF, 2, 0, 0, leak, lat);
        total++;
        if (hold_seen != 2 * RL) begin bad++; $display("FAIL burst_hold got=%0d want=%0d", hold_seen, 2 * RL); end
    endtask

    task automatic test_valid_stall();
        int clks = 0;
        int leak, lat;
        send_addr(12'h0F0, 1'b1, 5, 3, clks);
        send_beat(beat_of(8'h5A), 1'b0, clks);
        wait_ready(clks);
        total++;
        if (clks != AW + BW + 4) begin bad++; $display("FAIL stall_latency got=%0d want=%0d", clks, AW + BW + 4); end
        total++;
        if (dut.u_ram.mem[12'h0F0] !== 8'h5A) begin bad++; $display("FAIL stall_ram got=%h want=5a", dut.u_ram.mem[12'h0F0]); end
        exp_q.push_back(beat_of(8'h5A));
        read_txn(12'h0F0, 1, 0, 0, leak, lat);
    endtask

    task automatic test_ready_stall();
        int leak, lat;
        write_word(12'h200, 8'h3C);
        exp_q.push_back(beat_of(8'h3C));
        read_txn(12'h200, 1, 3, 2, leak, lat);
        total++;
        if (leak != 0) begin bad++; $display("FAIL ready_stall_valid got=%0d want=0", leak); end
    endtask

    task automatic test_reset_mid_write();
        int clks = 0;
        int leak, lat;
        write_word(12'h010, 8'h00);
        send_addr(12'h010, 1'b1, 0, 0, clks);
        repeat (3) begin s_valid = 1'b1; s_data = 1'b1; tick(); end
        reset = 1'b1; s_valid = 1'b1; s_data = 1'b1;
        tick();
        reset = 1'b0; s_valid = 1'b0;
        total++;
        if ({s_ready, s_hold} !== 2'b10) begin bad++; $display("FAIL reset_mid got=%b want=10", {s_ready, s_hold}); end
        tick();
        total++;
        if (dut.u_ram.mem[12'h010] !== 8'h00) begin bad++; $display("FAIL reset_ram got=%h want=00", dut.u_ram.mem[12'h010]); end
        exp_q.push_back(beat_of(8'h00));
        read_txn(12'h010, 1, 0, 0, leak, lat);
    endtask

`ifdef SERIAL_SLAVE_PARITY_EN
    task automatic test_parity();
        int clks = 0;
        int leak, lat;
        write_word(12'h040, 8'h77);
        err_seen = 0;
        send_addr(12'h040, 1'b1, 0, 0, clks);
        send_beat({8'h03, 1'b1}, 1'b0, clks);
        wait_ready(clks);
        total++;
        if (err_seen != 1) begin bad++; $display("FAIL parity_err got=%0d want=1", err_seen); end
        total++;
        if (dut.u_ram.mem[12'h040] !== 8'h77) begin bad++; $display("FAIL parity_ram got=%h want=77", dut.u_ram.mem[12'h040]); end
        err_seen = 0;
        send_addr(12'h040, 1'b1, 0, 0, clks);
        send_beat({8'h03, 1'b0}, 1'b0, clks);
        wait_ready(clks);
        total++;
        if (err_seen != 0) begin bad++; $display("FAIL parity_ok_err got=%0d want=0", err_seen); end
        exp_q.push_back({8'h03, 1'b0});
        read_txn(12'h040, 1, 0, 0, leak, lat);
    endtask
`endif

    task automatic test_random();
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int leak, lat;
        for (int n = 0; n < 6; n++) begin
            a = AW'($urandom);
            d = DW'($urandom);
            write_word(a, d);
            exp_q.push_back(beat_of(d));
            read_txn(a, 1, (n % 2 == 1) ? 1 + n : 0, 1, leak, lat);
            total++;
            if (leak != 0) begin bad++; $display("FAIL random_stall_valid n=%0d got=%0d want=0", n, leak); end
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        reset = 1'b1; s_address = 1'b0; s_data = 1'b0; s_valid = 1'b0;
        s_write_en = 1'b0; s_burst = 1'b0; bus_ready = 1'b1;
        test_reset();
        test_write_read();
        test_burst_wrap();
        test_valid_stall();
        test_ready_stall();
        test_reset_mid_write();
`ifdef SERIAL_SLAVE_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
